// File: rtl/cipher_ctrl.sv
// cipher_ctrl: load/rotate/multiply/store sequencer with a completed-operation counter.
// Define CIPHER_CTRL_READBACK_EN to add the CHECK readback state and the sticky err flag.
module cipher_ctrl #(
    parameter int WR_CYC = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       num,
    input  logic [1:0]       rot_amt,
    input  logic [7:0]       prod_in,
    input  logic [7:0]       rd_data,
    output logic             reg_en,
    output logic             rot_en,
    output logic             mem_we,
    output logic [3:0]       mem_addr,
    output logic             busy,
    output logic             done,
    output logic             ovr,
    output logic             err,
    output logic [CNT_W-1:0] op_cnt
);
    typedef enum logic [2:0] {
        IDLE, LOAD, ROTATE, MUL, WRITE, DONE
`ifdef CIPHER_CTRL_READBACK_EN
        , CHECK
`endif
    } state_t;

`ifdef CIPHER_CTRL_READBACK_EN
    localparam state_t POST_WR = CHECK;
`else
    localparam state_t POST_WR = DONE;
`endif

    state_t state, state_nxt;
    logic [3:0] num_q;
    logic [2:0] cnt;

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_nxt;

    // cnt holds the remaining rotate steps, then the remaining write cycles
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start ? LOAD : IDLE;
            LOAD:    state_nxt = cnt == 3'd0 ? MUL : ROTATE;
            ROTATE:  state_nxt = cnt == 3'd1 ? MUL : ROTATE;
            MUL:     state_nxt = WRITE;
            WRITE:   state_nxt = cnt == 3'd1 ? POST_WR : WRITE;
`ifdef CIPHER_CTRL_READBACK_EN
            CHECK:   state_nxt = DONE;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        reg_en   = state == LOAD;
        rot_en   = state == ROTATE;
        mem_we   = state == WRITE;
        busy     = state != IDLE;
        done     = state == DONE;
        mem_addr = num_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_q  <= '0;
            cnt    <= '0;
            ovr    <= 1'b0;
            op_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                num_q <= num;
                cnt   <= {1'b0, rot_amt};
            end
            if (state == ROTATE || state == WRITE) cnt <= cnt - 3'd1;
            if (state == MUL) cnt <= 3'(WR_CYC);
            if (start) ovr <= state != IDLE;
            if (state == DONE) op_cnt <= op_cnt + 1'b1;
        end
    end

`ifdef CIPHER_CTRL_READBACK_EN
    always_ff @(posedge clk)
        if (rst) err <= 1'b0;
        else if (state == CHECK && rd_data != prod_in) err <= 1'b1;
`else
    logic unused_rd;
    assign unused_rd = ^{rd_data, prod_in};
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cipher_ctrl.sv
// tb_cipher_ctrl: scoreboard bench for cipher_ctrl (WR_CYC=1 main instance, WR_CYC=3 reset instance).
module tb_cipher_ctrl;
`ifdef CIPHER_CTRL_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic clk, rst, start;
    logic [3:0] num;
    logic [1:0] rot_amt;
    logic [7:0] prod_in, rd_data;
    logic reg_en, rot_en, mem_we, busy, done, ovr, err;
    logic [3:0] mem_addr;
    logic [7:0] op_cnt;

    logic rst3, start3;
    logic [3:0] num3;
    logic [1:0] rot3;
    logic reg_en3, rot_en3, mem_we3, busy3, done3, ovr3, err3;
    logic [3:0] mem_addr3;
    logic [7:0] op_cnt3;

    cipher_ctrl #(.WR_CYC(1), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .start(start), .num(num), .rot_amt(rot_amt),
        .prod_in(prod_in), .rd_data(rd_data), .reg_en(reg_en), .rot_en(rot_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .busy(busy), .done(done),
        .ovr(ovr), .err(err), .op_cnt(op_cnt)
    );

    cipher_ctrl #(.WR_CYC(3), .CNT_W(8)) u3 (
        .clk(clk), .rst(rst3), .start(start3), .num(num3), .rot_amt(rot3),
        .prod_in(prod_in), .rd_data(rd_data), .reg_en(reg_en3), .rot_en(rot_en3),
        .mem_we(mem_we3), .mem_addr(mem_addr3), .busy(busy3), .done(done3),
        .ovr(ovr3), .err(err3), .op_cnt(op_cnt3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] num;
        int         rot;
        logic [7:0] cnt;
        logic       err;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;
    logic [7:0] model_cnt = '0;
    logic err_model = 1'b0;
    int n_ops = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, a, e);
        end
    endtask

    // Monitor: an operation's expectation is popped when its LOAD cycle appears
    exp_t cur;
    int cyc = 0, l = 0, rotn = 0, wen = 0, fr = 0, fw = 0, addr_bad = 0;
    bit act = 0;
    always @(negedge clk) begin
        cyc++;
        if (reg_en) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_load at cycle %0d", cyc);
            end else begin
                cur = q.pop_front();
                act = 1;
                l = cyc;
                rotn = 0;
                wen = 0;
                fr = 0;
                fw = 0;
                addr_bad = 0;
            end
        end
        if (act && rot_en) begin
            if (rotn == 0) fr = cyc;
            rotn++;
        end
        if (act && mem_we) begin
            if (wen == 0) fw = cyc;
            wen++;
            if (mem_addr !== cur.num) addr_bad++;
        end
        if (done && !act) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_done at cycle %0d", cyc);
        end
        if (act && done) begin
            chk("latency", cyc - l, 2 + cur.rot + 1 + RB);
            chk("rot_cycles", rotn, cur.rot);
            if (cur.rot > 0) chk("rot_first", fr, l + 1);
            chk("we_cycles", wen, 1);
            chk("we_first", fw, l + 2 + cur.rot);
            chk("we_addr_bad", addr_bad, 0);
            chk("op_cnt_at_done", op_cnt, cur.cnt);
            chk("err_at_done", err, cur.err);
            chk("busy_at_done", busy, 1);
            act = 0;
        end
    end

    // mode 1: extra start in cycle 2; mode 2: start during the DONE cycle
    task automatic op(input logic [3:0] n, input logic [1:0] r, input int mode);
        exp_t e;
        int k;
        @(posedge clk);
        #1;
        start = 1;
        num = n;
        rot_amt = r;
        err_model = err_model | (RB == 1 && rd_data != prod_in);
        e.num = n;
        e.rot = r;
        e.cnt = model_cnt;
        e.err = err_model;
        q.push_back(e);
        model_cnt++;
        n_ops++;
        @(posedge clk);
        #1;
        start = 0;
        num = 4'($urandom);
        rot_amt = 2'($urandom);
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) chk("ovr_clear_on_accept", ovr, 0);
            start = (mode == 1 && k == 2);
            if (done) break;
        end
        if (k > 40) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got none want done within 40 cycles");
        end
        if (mode == 1) chk("ovr_set_busy", ovr, 1);
        if (mode == 2) begin
            start = 1;
            @(posedge clk);
            #1;
            start = 0;
            @(negedge clk);
            chk("ovr_start_in_done", ovr, 1);
            chk("start_in_done_ignored", busy, 0);
        end
    endtask

    initial begin
        int wn, c;
        clk = 0;
        rst = 1;
        start = 0;
        num = 0;
        rot_amt = 0;
        prod_in = 8'h5a;
        rd_data = 8'h5a;
        rst3 = 1;
        start3 = 0;
        num3 = 0;
        rot3 = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        rst3 = 0;
        @(negedge clk);
        chk("rst_reg_en", reg_en, 0);
        chk("rst_rot_en", rot_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_err", err, 0);
        chk("rst_op_cnt", op_cnt, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst3_busy", busy3, 0);

        op(4'd5, 2'd2, 0);
        @(negedge clk);
        chk("op_cnt_first", op_cnt, 1);
        op(4'($urandom), 2'd0, 0);
        op(4'($urandom), 2'($urandom), 1);
        op(4'($urandom), 2'($urandom), 0);
        op(4'($urandom), 2'($urandom), 2);
        while (n_ops < 256)
            op(4'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0) ? 1 : 0);
        @(negedge clk);
        chk("op_cnt_wrap", op_cnt, 0);

        rd_data = 8'h12;
        prod_in = 8'h21;
        op(4'd3, 2'd1, 0);
        @(negedge clk);
        chk("err_after_check", err, RB);
        rd_data = 8'h21;
        op(4'($urandom), 2'($urandom), 0);
        @(negedge clk);
        chk("err_sticky", err, RB);
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_cnt = 0;
        err_model = 0;
        @(negedge clk);
        chk("err_cleared_by_rst", err, 0);
        chk("op_cnt_cleared_by_rst", op_cnt, 0);

        @(posedge clk);
        #1;
        start3 = 1;
        num3 = 4'd9;
        rot3 = 2'd1;
        @(posedge clk);
        #1;
        start3 = 0;
        wn = 0;
        for (int k = 0; k < 20 && wn < 2; k++) begin
            @(negedge clk);
            if (mem_we3) wn++;
        end
        chk("wr3_reached", wn, 2);
        rst3 = 1;
        @(posedge clk);
        #1;
        rst3 = 0;
        @(negedge clk);
        chk("rst_mid_write_we", mem_we3, 0);
        chk("rst_mid_write_busy", busy3, 0);
        chk("rst_mid_write_cnt", op_cnt3, 0);
        chk("rst_mid_write_done", done3, 0);
        chk("rst_mid_write_addr", mem_addr3, 0);

        @(posedge clk);
        #1;
        start3 = 1;
        num3 = 4'd4;
        rot3 = 2'd0;
        @(posedge clk);
        #1;
        start3 = 0;
        wn = 0;
        for (c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) chk("u3_load_after_rst", reg_en3, 1);
            if (mem_we3) wn++;
            if (done3) break;
        end
        chk("u3_done_cycle", c, 6 + RB);
        chk("u3_we_cycles", wn, 3);
        @(negedge clk);
        chk("u3_op_cnt", op_cnt3, 1);

        chk("sb_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cipher_ctrl.md
CIPHER_CTRL -- requirements
Module: cipher_ctrl

Interface
REQ-001 The block SHALL have parameter WR_CYC, default 1, giving the number of cycles mem_we is held per write (legal range 1-4).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the completed-operation counter.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request one load/rotate/multiply/store operation.
REQ-006 The block SHALL have port num, input, 4 bits: operand, also the memory write address.
REQ-007 The block SHALL have port rot_amt, input, 2 bits: number of rotator steps (0-3).
REQ-008 The block SHALL have port prod_in, input, 8 bits: datapath multiplier result, zero-extended.
REQ-009 The block SHALL have port rd_data, input, 8 bits: memory read data at mem_addr.
REQ-010 The block SHALL have port reg_en, output, 1 bit: operand register load enable.
REQ-011 The block SHALL have port rot_en, output, 1 bit: rotator step enable.
REQ-012 The block SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-013 The block SHALL have port mem_addr, output, 4 bits: memory address.
REQ-014 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-015 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-016 The block SHALL have port ovr, output, 1 bit: sticky flag set when start arrives while busy.
REQ-017 The block SHALL have port err, output, 1 bit: readback mismatch, sticky.
REQ-018 The block SHALL have port op_cnt, output, CNT_W bits: count of completed operations.

Function
REQ-019 The FSM SHALL use the states IDLE, LOAD, ROTATE, MUL, WRITE, CHECK and DONE, with all outputs decoded Moore-style from registered state.
REQ-020 In IDLE with start=1, the block SHALL latch num and rot_amt, clear ovr, and move to LOAD; in IDLE with start=0 it SHALL remain in IDLE.
REQ-021 LOAD SHALL assert reg_en for exactly 1 cycle and then move to ROTATE, or directly to MUL if the latched rot_amt=0.
REQ-022 ROTATE SHALL assert rot_en for exactly rot_amt consecutive cycles, using a down-counter, and then move to MUL.
REQ-023 MUL SHALL be a 1-cycle settle state with no enables asserted, followed by WRITE.
REQ-024 WRITE SHALL assert mem_we for exactly WR_CYC cycles, with mem_addr equal to the latched num, and then move to CHECK if READBACK is compiled in, otherwise to DONE.
REQ-025 Outside WRITE and CHECK, mem_addr SHALL hold the latched num, and mem_we SHALL be 0.
REQ-026 DONE SHALL assert done for 1 cycle, increment op_cnt (wrapping from 2^CNT_W-1 to 0), and return to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 Latency: with start sampled at edge 0, reg_en SHALL be high in cycle 1, and done SHALL be high in cycle 3+rot_amt+WR_CYC (plus 1 cycle with READBACK).
REQ-029 start=1 while busy SHALL be ignored for sequencing and SHALL set ovr; ovr SHALL stay set until the next accepted start.
REQ-030 start=1 in the DONE cycle SHALL count as busy (set ovr); start in the following IDLE cycle SHALL be accepted.
REQ-031 Changes on num or rot_amt after acceptance SHALL have no effect on the operation in progress.

Reset
REQ-032 When rst=1 at a clock edge, the block SHALL enter IDLE, and reg_en, rot_en, mem_we, busy, done, ovr, err and op_cnt SHALL all be 0, with mem_addr=0.
REQ-033 rst SHALL take priority over start and over every state, including mid-WRITE, where mem_we SHALL drop in the next cycle.

Configuration
REQ-034 With macro CIPHER_CTRL_READBACK_EN defined, the CHECK state SHALL exist: it lasts 1 cycle with mem_we=0, compares rd_data to prod_in, and sets err if they differ.
REQ-035 Without CIPHER_CTRL_READBACK_EN, the CHECK state SHALL be absent, err SHALL be tied to 0, and rd_data SHALL be unused.

Verification
REQ-036 The bench SHALL drive rst, then start with num=5 and rot_amt=2 (WR_CYC=1, no macro), and require: reg_en in cycle 1, rot_en in cycles 2-3, mem_we with mem_addr=5 in cycle 5, done in cycle 6, op_cnt=1.
REQ-037 The bench SHALL drive rot_amt=0, and require that rot_en never asserts and that done arrives in cycle 4.
REQ-038 The bench SHALL pulse start in cycle 2 of a running operation, and require ovr=1, an unchanged sequence, and ovr cleared on the next accepted start.
REQ-039 The bench SHALL assert rst during WRITE with WR_CYC=3, and require that in the next cycle mem_we=0, busy=0, op_cnt is unchanged-from-reset (0) and the state is IDLE.
REQ-040 The bench SHALL run 256 back-to-back operations with CNT_W=8, and require op_cnt to wrap to 0.
REQ-041 The bench SHALL, with READBACK compiled in, drive rd_data=0x12 and prod_in=0x21, and require err=1 in the cycle after CHECK, sticky until rst.
